// File: rtl/interleaver_pingpong_ctrl.sv
// Ping-pong block interleaver controller: FEC bits land at permuted addresses in one bank while the
// other, completed bank drains in natural order as Ncpc-bit symbols. Optional macro: IL_BYPASS_EN.
module interleaver_pingpong_ctrl #(
  parameter int Ncbps = 192,
  parameter int Ncpc  = 2,
  parameter int d     = 16
) (
  input  logic            clk,
  input  logic            resetN,
`ifdef IL_BYPASS_EN
  input  logic            bypass,
`endif
  input  logic            in_valid,
  input  logic            in_data,
  output logic            in_ready,
  input  logic            out_ready,
  output logic            out_valid,
  output logic [Ncpc-1:0] out_data,
  output logic            out_last,
  output logic            busy
);

  localparam int S    = (Ncpc / 2 > 1) ? Ncpc / 2 : 1;
  localparam int NSYM = Ncbps / Ncpc;
  localparam int AW   = $clog2(Ncbps);
  localparam int IW   = $clog2(NSYM);
  localparam int PW   = $clog2(Ncbps * d) + 1;

  typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} bank_st_t;

  bank_st_t         bank_st [2];
  logic [Ncbps-1:0] mem [2];
  logic             wsel;
  logic             rsel;
  logic [AW-1:0]    k;
  logic [IW-1:0]    i;
  logic [IW-1:0]    i_nxt;
  logic [AW-1:0]    wr_addr;
  logic             wr_en;
  logic             wr_done;
  logic             wr_byp;

  // Two-step permutation; intermediates are wide enough that d*m never truncates.
  function automatic logic [AW-1:0] perm_addr(input logic [AW-1:0] kk);
    logic [PW-1:0] kw;
    logic [PW-1:0] m;
    logic [PW-1:0] t;
    logic [PW-1:0] j;
    kw = PW'(kk);
    m  = PW'(Ncbps / d) * (kw % PW'(d)) + kw / PW'(d);
    t  = m + PW'(Ncbps) - (PW'(d) * m) / PW'(Ncbps);
    j  = PW'(S) * (m / PW'(S)) + (t % PW'(S));
    return AW'(j);
  endfunction

  function automatic logic [Ncpc-1:0] sym_at(input logic sel, input logic [IW-1:0] idx);
    logic [AW-1:0] base;
    base = AW'(idx) * AW'(Ncpc);
    return mem[sel][base +: Ncpc];
  endfunction

`ifdef IL_BYPASS_EN
  logic byp_q [2];

  // Bypass is captured while the write bank is still empty and then frozen for the block.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      byp_q[0] <= 1'b0;
      byp_q[1] <= 1'b0;
    end else if (bank_st[wsel] == EMPTY) begin
      byp_q[wsel] <= bypass;
    end
  end

  assign wr_byp = (bank_st[wsel] == EMPTY) ? bypass : byp_q[wsel];
`else
  assign wr_byp = 1'b0;
`endif

  assign in_ready = (bank_st[wsel] == EMPTY) || (bank_st[wsel] == FILLING);
  assign busy     = (bank_st[0] != EMPTY) || (bank_st[1] != EMPTY);
  assign wr_en    = in_valid && in_ready;
  assign wr_done  = wr_en && (k == AW'(Ncbps - 1));
  assign wr_addr  = wr_byp ? k : perm_addr(k);
  assign i_nxt    = i + IW'(1);

  // Write stage: bank storage carries no reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wsel][wr_addr] <= in_data;
  end

  // Control and output stage: bank sequencing plus the registered symbol presented to the mapper.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      wsel       <= 1'b0;
      rsel       <= 1'b0;
      k          <= '0;
      i          <= '0;
      bank_st[0] <= EMPTY;
      bank_st[1] <= EMPTY;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_last   <= 1'b0;
    end else begin
      if (wr_en) begin
        if (wr_done) begin
          k             <= '0;
          wsel          <= ~wsel;
          bank_st[wsel] <= FULL;
        end else begin
          k             <= k + AW'(1);
          bank_st[wsel] <= FILLING;
        end
      end

      if (!out_valid) begin
        if (bank_st[rsel] == FULL) begin
          out_valid <= 1'b1;
          out_data  <= sym_at(rsel, '0);
          out_last  <= 1'b0;
          i         <= '0;
        end
      end else if (out_ready) begin
        if (out_last) begin
          bank_st[rsel] <= EMPTY;
          rsel          <= ~rsel;
          i             <= '0;
          // Chain straight into the other bank when it is already complete.
          if (bank_st[~rsel] == FULL) begin
            out_data <= sym_at(~rsel, '0);
            out_last <= 1'b0;
          end else begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
          end
        end else begin
          bank_st[rsel] <= DRAINING;
          i             <= i_nxt;
          out_data      <= sym_at(rsel, i_nxt);
          out_last      <= (i_nxt == IW'(NSYM - 1));
        end
      end
    end
  end

endmodule

// File: tb/tb_interleaver_pingpong_ctrl.sv
// Directed self-checking bench for interleaver_pingpong_ctrl (default build, permutation always on).
module tb_interleaver_pingpong_ctrl;

  localparam int NCBPS = 192;
  localparam int NCPC  = 2;
  localparam int D     = 16;
  localparam int S     = 1;
  localparam int NSYM  = NCBPS / NCPC;

  logic            clk = 1'b0;
  logic            resetN = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_data = 1'b0;
  logic            in_ready;
  logic            out_ready = 1'b0;
  logic            out_valid;
  logic [NCPC-1:0] out_data;
  logic            out_last;
  logic            busy;

  int checks = 0;
  int failures = 0;
  int cyc_ctr = 0;

  logic [1:0] got_d [$];
  logic       got_l [$];
  int         got_c [$];

  interleaver_pingpong_ctrl #(.Ncbps(NCBPS), .Ncpc(NCPC), .d(D)) dut (
    .clk(clk), .resetN(resetN),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_ctr <= cyc_ctr + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  // Reference interleaver: bank[j(k)] = data[k].
  function automatic logic [NCBPS-1:0] interleave(input logic [NCBPS-1:0] data);
    logic [NCBPS-1:0] bank;
    bank = '0;
    for (int k = 0; k < NCBPS; k++) begin
      int m;
      int j;
      m = (NCBPS / D) * (k % D) + k / D;
      j = S * (m / S) + ((m + NCBPS - (D * m) / NCBPS) % S);
      bank[j] = data[k];
    end
    return bank;
  endfunction

  function automatic logic [NCBPS-1:0] rand_block();
    logic [NCBPS-1:0] v;
    for (int k = 0; k < NCBPS; k++) v[k] = 1'($urandom_range(0, 1));
    return v;
  endfunction

  task automatic write_bits(input logic [NCBPS-1:0] data, input int nbits, output int stalls);
    int n;
    int cyc;
    n = 0;
    cyc = 0;
    stalls = 0;
    while (n < nbits && cyc < 4000) begin
      in_valid = 1'b1;
      in_data  = data[n];
      @(negedge clk);
      if (in_ready) n++;
      else stalls++;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    in_data  = 1'b0;
    checks++;
    if (n != nbits) begin
      failures++;
      $display("FAIL write_timeout accepted=%0d required=%0d", n, nbits);
    end
  endtask

  task automatic collect(input int nsym);
    int n;
    int cyc;
    n = 0;
    cyc = 0;
    while (n < nsym && cyc < nsym * 8 + 600) begin
      out_ready = 1'b1;
      @(negedge clk);
      if (out_valid && out_ready) begin
        got_d.push_back(out_data);
        got_l.push_back(out_last);
        got_c.push_back(cyc_ctr);
        n++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (n != nsym) begin
      failures++;
      $display("FAIL collect_timeout got=%0d required=%0d", n, nsym);
    end
  endtask

  task automatic clear_rx();
    got_d.delete();
    got_l.delete();
    got_c.delete();
  endtask

  task automatic test_reset();
    resetN = 1'b0; in_valid = 1'b0; in_data = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_data !== 2'b00) begin failures++; $display("FAIL reset_out_data got=%b exp=00", out_data); end
    checks++; if (out_last !== 1'b0) begin failures++; $display("FAIL reset_out_last got=%b exp=0", out_last); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    resetN = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_idle in_ready=%b busy=%b out_valid=%b exp 1/0/0", in_ready, busy, out_valid);
    end
  endtask

  // k=1 one-hot lands at j=12 -> symbol 6, bit 0.
  task automatic test_single_block();
    logic [NCBPS-1:0] data;
    int st;
    clear_rx();
    data = '0;
    data[1] = 1'b1;
    out_ready = 1'b1;
    write_bits(data, NCBPS, st);
    checks++; if (st != 0) begin failures++; $display("FAIL single_stalls got=%0d exp=0", st); end
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL single_latency_early out_valid=%b busy=%b exp 0/1", out_valid, busy);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 2'b00 || out_last !== 1'b0) begin
      failures++;
      $display("FAIL single_first_valid out_valid=%b data=%b last=%b exp 1/00/0", out_valid, out_data, out_last);
    end
    collect(NSYM);
    checks++; if (got_d.size() != NSYM) begin failures++; $display("FAIL single_count got=%0d exp=%0d", got_d.size(), NSYM); end
    for (int b = 0; b < got_d.size(); b++) begin
      logic [1:0] ed;
      ed = (b == 6) ? 2'b01 : 2'b00;
      checks++;
      if (got_d[b] !== ed || got_l[b] !== 1'(b == NSYM - 1)) begin
        failures++;
        $display("FAIL single_beat%0d data=%b last=%b exp %b/%b", b, got_d[b], got_l[b], ed, 1'(b == NSYM - 1));
      end
    end
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL single_idle busy=%b out_valid=%b in_ready=%b exp 0/0/1", busy, out_valid, in_ready);
    end
  endtask

  // k=16 -> j=1 (beat 0 = 10), k=15 -> j=180 (beat 90 = 01), k=191 -> j=191 (beat 95 = 10).
  task automatic test_addr_spot();
    int         ks [3]  = '{16, 15, 191};
    int         bts [3] = '{0, 90, 95};
    logic [1:0] vs [3]  = '{2'b10, 2'b01, 2'b10};
    for (int t = 0; t < 3; t++) begin
      logic [NCBPS-1:0] data;
      int st;
      clear_rx();
      data = '0;
      data[ks[t]] = 1'b1;
      write_bits(data, NCBPS, st);
      collect(NSYM);
      for (int b = 0; b < got_d.size(); b++) begin
        logic [1:0] ed;
        ed = (b == bts[t]) ? vs[t] : 2'b00;
        checks++;
        if (got_d[b] !== ed) begin
          failures++;
          $display("FAIL addr_spot_k%0d beat%0d got=%b exp=%b", ks[t], b, got_d[b], ed);
        end
      end
    end
  endtask

  // Block n carries bit n of k, so any two distinct k differ in at least one block.
  task automatic test_addr_golden();
    for (int n = 0; n < 8; n++) begin
      logic [NCBPS-1:0] data;
      logic [NCBPS-1:0] exp_bank;
      logic [7:0] kv;
      int st;
      clear_rx();
      for (int k = 0; k < NCBPS; k++) begin
        kv = 8'(k);
        data[k] = kv[n];
      end
      exp_bank = interleave(data);
      write_bits(data, NCBPS, st);
      collect(NSYM);
      for (int b = 0; b < got_d.size(); b++) begin
        checks++;
        if (got_d[b] !== exp_bank[2*b +: 2]) begin
          failures++;
          $display("FAIL addr_golden_bit%0d beat%0d got=%b exp=%b", n, b, got_d[b], exp_bank[2*b +: 2]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [NCBPS-1:0] d0, d1, e0, e1;
    int s0, s1, gaps, lasts;
    clear_rx();
    d0 = rand_block();
    d1 = rand_block();
    e0 = interleave(d0);
    e1 = interleave(d1);
    out_ready = 1'b1;
    fork
      begin
        write_bits(d0, NCBPS, s0);
        write_bits(d1, NCBPS, s1);
      end
      collect(2 * NSYM);
    join
    checks++; if (s0 + s1 != 0) begin failures++; $display("FAIL b2b_in_ready_drop stalls=%0d exp=0", s0 + s1); end
    checks++; if (got_d.size() != 2 * NSYM) begin failures++; $display("FAIL b2b_count got=%0d exp=%0d", got_d.size(), 2 * NSYM); end
    gaps = 0;
    lasts = 0;
    for (int b = 0; b < got_d.size(); b++) begin
      logic [1:0] ed;
      ed = (b < NSYM) ? e0[2*b +: 2] : e1[2*(b-NSYM) +: 2];
      if (got_l[b]) lasts++;
      if ((b % NSYM) != 0 && got_c[b] - got_c[b-1] != 1) gaps++;
      checks++;
      if (got_d[b] !== ed || got_l[b] !== 1'((b % NSYM) == NSYM - 1)) begin
        failures++;
        $display("FAIL b2b_beat%0d data=%b last=%b exp %b/%b", b, got_d[b], got_l[b], ed, 1'((b % NSYM) == NSYM - 1));
      end
    end
    checks++; if (gaps != 0) begin failures++; $display("FAIL b2b_out_gaps got=%0d exp=0", gaps); end
    checks++; if (lasts != 2) begin failures++; $display("FAIL b2b_last_count got=%0d exp=2", lasts); end
  endtask

  task automatic test_backpressure();
    logic [NCBPS-1:0] d0, d1, e0, e1;
    int s0, s1, leaks, n, cyc;
    logic ri_before;
    clear_rx();
    d0 = rand_block();
    d1 = rand_block();
    e0 = interleave(d0);
    e1 = interleave(d1);
    out_ready = 1'b0;
    write_bits(d0, NCBPS, s0);
    write_bits(d1, NCBPS, s1);
    checks++; if (s0 + s1 != 0) begin failures++; $display("FAIL bp_fill_stalls got=%0d exp=0", s0 + s1); end
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b1 || out_valid !== 1'b1 || out_data !== e0[1:0]) begin
      failures++;
      $display("FAIL bp_full in_ready=%b busy=%b out_valid=%b data=%b exp 0/1/1/%b", in_ready, busy, out_valid, out_data, e0[1:0]);
    end
    leaks = 0;
    for (int c = 0; c < 10; c++) begin
      in_valid = 1'b1;
      in_data  = 1'b1;
      @(negedge clk);
      if (in_ready !== 1'b0) leaks++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_data  = 1'b0;
    checks++; if (leaks != 0) begin failures++; $display("FAIL bp_in_ready_high cycles=%0d exp=0", leaks); end
    out_ready = 1'b1;
    n = 0;
    cyc = 0;
    ri_before = 1'bx;
    while (n < NSYM && cyc < 1000) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        got_d.push_back(out_data);
        got_l.push_back(out_last);
        got_c.push_back(cyc_ctr);
        ri_before = in_ready;
        n++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    checks++; if (n != NSYM) begin failures++; $display("FAIL bp_release_timeout got=%0d exp=%0d", n, NSYM); end
    checks++;
    if (ri_before !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_in_ready_return before=%b after=%b exp 0/1", ri_before, in_ready);
    end
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_chain_gap out_valid=%b exp=1", out_valid); end
    collect(NSYM);
    for (int b = 0; b < got_d.size(); b++) begin
      logic [1:0] ed;
      ed = (b < NSYM) ? e0[2*b +: 2] : e1[2*(b-NSYM) +: 2];
      checks++;
      if (got_d[b] !== ed || got_l[b] !== 1'((b % NSYM) == NSYM - 1)) begin
        failures++;
        $display("FAIL bp_beat%0d data=%b last=%b exp %b/%b", b, got_d[b], got_l[b], ed, 1'((b % NSYM) == NSYM - 1));
      end
    end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL bp_idle busy=%b exp=0", busy); end
  endtask

  task automatic test_random_stall();
    logic [NCBPS-1:0] d0, d1, e0, e1;
    int s0, s1, n, cyc;
    logic pv, pr, pl;
    logic [1:0] pd;
    clear_rx();
    d0 = rand_block();
    d1 = rand_block();
    e0 = interleave(d0);
    e1 = interleave(d1);
    n = 0; cyc = 0; pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = 2'b00;
    fork
      begin
        write_bits(d0, NCBPS, s0);
        write_bits(d1, NCBPS, s1);
      end
      begin
        while (n < 2 * NSYM && cyc < 3000) begin
          out_ready = 1'($urandom_range(0, 1));
          @(negedge clk);
          if (pv && !pr) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== pd || out_last !== pl) begin
              failures++;
              $display("FAIL stall_hold valid=%b data=%b last=%b exp 1/%b/%b", out_valid, out_data, out_last, pd, pl);
            end
          end
          pv = out_valid; pr = out_ready; pd = out_data; pl = out_last;
          if (out_valid && out_ready) begin
            got_d.push_back(out_data);
            got_l.push_back(out_last);
            n++;
          end
          @(posedge clk); #1;
          cyc++;
        end
      end
    join
    checks++; if (n != 2 * NSYM) begin failures++; $display("FAIL stall_count got=%0d exp=%0d", n, 2 * NSYM); end
    for (int b = 0; b < got_d.size(); b++) begin
      logic [1:0] ed;
      ed = (b < NSYM) ? e0[2*b +: 2] : e1[2*(b-NSYM) +: 2];
      checks++;
      if (got_d[b] !== ed || got_l[b] !== 1'((b % NSYM) == NSYM - 1)) begin
        failures++;
        $display("FAIL stall_beat%0d data=%b last=%b exp %b/%b", b, got_d[b], got_l[b], ed, 1'((b % NSYM) == NSYM - 1));
      end
    end
  endtask

  task automatic test_reset_midblock();
    logic [NCBPS-1:0] da, db, dc, ec;
    int st;
    clear_rx();
    da = rand_block();
    db = rand_block();
    dc = rand_block();
    ec = interleave(dc);
    out_ready = 1'b0;
    write_bits(da, NCBPS, st);
    write_bits(db, 100, st);
    resetN = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midrst_out_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL midrst_in_ready got=%b exp=1", in_ready); end
    @(posedge clk); #1;
    resetN = 1'b1;
    @(posedge clk); #1;
    write_bits(dc, NCBPS, st);
    checks++; if (st != 0) begin failures++; $display("FAIL midrst_stalls got=%0d exp=0", st); end
    collect(NSYM);
    for (int b = 0; b < got_d.size(); b++) begin
      checks++;
      if (got_d[b] !== ec[2*b +: 2] || got_l[b] !== 1'(b == NSYM - 1)) begin
        failures++;
        $display("FAIL midrst_beat%0d data=%b last=%b exp %b/%b", b, got_d[b], got_l[b], ec[2*b +: 2], 1'(b == NSYM - 1));
      end
    end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_idle busy=%b exp=0", busy); end
  endtask

  initial begin
    test_reset();
    test_single_block();
    test_addr_spot();
    test_addr_golden();
    test_back_to_back();
    test_backpressure();
    test_random_stall();
    test_reset_midblock();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/interleaver_pingpong_ctrl.md
Name: interleaver_pingpong_ctrl

Overview:
- Block-level controller that turns the per-bit interleaver index stream into a real, flow-controlled block interleaver.
- FEC bits are written into one of two Ncbps-bit banks at the permuted address j(k). The other, completed bank is drained in natural order to the mapper as Ncpc-bit symbols.
- Sits between the FEC encoder and the QPSK/QAM modulator. Owns bank scheduling, back-pressure and block sequencing.

Parameters:
- Ncbps, 192, coded bits per block (multiple of d and of Ncpc)
- Ncpc, 2, coded bits per carrier, equals output symbol width
- d, 16, interleaver column count
- s, Ncpc/2, rotation term (fixed at max(Ncpc/2,1))

Ports:
- clk  input  1  clock, all logic rising-edge
- resetN  input  1  reset, asynchronous, active-low
- in_valid  input  1  FEC bit valid
- in_data  input  1  FEC coded bit
- in_ready  output  1  controller can accept a bit this cycle
- out_ready  input  1  modulator accepts a symbol
- out_valid  output  1  out_data holds a valid symbol
- out_data  output  Ncpc  symbol; out_data[b] = bank[Ncpc*i + b]
- out_last  output  1  high with the final symbol (i = Ncbps/Ncpc-1) of a block
- busy  output  1  any bank in FILLING, FULL or DRAINING

Behaviour:
- Reset values:
  - wsel=0, rsel=0; both banks EMPTY; write counter k=0, read counter i=0.
  - in_ready=1, out_valid=0, out_data=0, out_last=0, busy=0.
  - Bank contents are not reset.
- Per-bank state: EMPTY -> FILLING (first accepted write) -> FULL (write at k=Ncbps-1 accepted) -> DRAINING (first symbol accepted) -> EMPTY (symbol with out_last accepted).
- Write side:
  - Accept when in_valid & in_ready.
  - Address: m = (Ncbps/d)*(k mod d) + k/d; j = s*(m/s) + ((m + Ncbps - (d*m)/Ncbps) mod s). Computed combinationally from k.
  - bank[wsel][j] <= in_data.
  - k increments; at k=Ncbps-1 it wraps to 0, wsel toggles, and the bank goes FULL.
- in_ready = bank[wsel] is EMPTY or FILLING. It deasserts when both banks are FULL/DRAINING and re-asserts the cycle after the draining bank returns to EMPTY.
- Read side:
  - out_valid is registered. It asserts the cycle after bank[rsel] becomes FULL, so the first symbol appears 1 cycle after the last write of a block.
  - Hold out_data, out_valid and out_last stable while out_valid & !out_ready.
  - On accept, i increments and the next symbol is presented the next cycle with no bubble.
  - At i=Ncbps/Ncpc-1: out_last=1; on accept i=0, rsel toggles, the bank goes EMPTY.
  - If the other bank is already FULL, out_valid stays high with no gap.
- Simultaneous events:
  - A write completing bank A in the same cycle that bank B finishes draining is legal. A becomes FULL, B becomes EMPTY, and in_ready is 1 next cycle.
  - Reads never touch bank[wsel] while it is FILLING.
- Arithmetic:
  - k, j are $clog2(Ncbps) bits; i is $clog2(Ncbps/Ncpc) bits.
  - Intermediate products use $clog2(Ncbps*d)+1 bits so there is no truncation.
- Reset mid-operation discards partial and full blocks and returns all state to the reset values above.
- in_valid while in_ready=0 is ignored (no write, no k change).

Optional Feature:
- IL_BYPASS_EN:
  - When defined, adds input port bypass (1 bit), sampled only when the write bank is EMPTY and latched per bank for the whole block. A bypassed block uses j=k (natural order); drain behaviour is unchanged.
  - When undefined, the port does not exist and the permutation is always applied.

Test Plan:
- Single block, all-zero input except k=1 set to 1 (j=12), out_ready=1 -> 96 symbols; only beat 6 (0-based) = 2'b01; out_last on beat 95; first out_valid 1 cycle after 192nd write.
- Address spot check: k=16 -> j=1, k=191 -> j=191, k=15 -> j=180; verify against a golden model for all k.
- Back-to-back blocks, continuous in_valid, out_ready=1 -> in_ready never drops; out_valid is continuous after the first block; 2 blocks give 192 symbols.
- out_ready=0 held -> after two blocks (384 writes) in_ready=0 and further in_valid is ignored; releasing out_ready gives in_ready=1 again one cycle after the 96th symbol is accepted.
- Random out_ready toggling -> symbols are never dropped or duplicated; out_data is stable while stalled.
- Assert resetN low at write k=100 -> next cycle busy=0, out_valid=0, in_ready=1; a subsequent fresh block drains correctly.
